// File: rtl/ircam_frame_parser.sv
// IR camera byte-stream parser: header lock, pixel forwarding with sof/eol markers and inter-byte timeout.
// Define IRCAM_FRAME_CHKSUM_EN to consume and verify the trailing 8-bit checksum byte.
module ircam_frame_parser #(
  parameter logic [7:0] HDR0        = 8'h5A,
  parameter logic [7:0] HDR1        = 8'hA5,
  parameter int         ROW_BYTES   = 26,
  parameter int         ROWS        = 24,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       din_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  output logic [7:0] o_data,
  output logic       o_data_vld,
  output logic       o_sof,
  output logic       o_eol,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef IRCAM_FRAME_CHKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_GOT_H0, S_PAYLOAD, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GOT_H0, S_PAYLOAD} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
`ifdef IRCAM_FRAME_CHKSUM_EN
  logic [7:0]    sum_q, sum_d;
`else
  logic          pend_q, pend_d;
`endif

  logic tmo_hit;
  logic col_last;
  logic row_last;

  assign tmo_hit  = !i_byte_vld && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign col_last = (col_q == CW'(ROW_BYTES - 1));
  assign row_last = (row_q == RW'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef IRCAM_FRAME_CHKSUM_EN
    sum_d   = sum_q;
`else
    pend_d  = 1'b0;
    done_d  = pend_q;
`endif

    if (!en) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      tmo_d   = '0;
      done_d  = 1'b0;
`ifdef IRCAM_FRAME_CHKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      if (state_q != S_IDLE) begin
        tmo_d = i_byte_vld ? '0 : tmo_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          tmo_d = '0;
          if (i_byte_vld && (i_byte == HDR0)) state_d = S_GOT_H0;
        end
        S_GOT_H0: begin
          if (i_byte_vld) begin
            if (i_byte == HDR0)      state_d = S_GOT_H0;
            else if (i_byte == HDR1) state_d = S_PAYLOAD;
            else                     state_d = S_IDLE;
            col_d = '0;
            row_d = '0;
`ifdef IRCAM_FRAME_CHKSUM_EN
            sum_d = '0;
`endif
          end else if (tmo_hit) begin
            state_d = S_IDLE;
            tmo_d   = '0;
          end
        end
        S_PAYLOAD: begin
          if (i_byte_vld) begin
            data_d = i_byte;
            vld_d  = 1'b1;
            sof_d  = (row_q == '0) && (col_q == '0);
            eol_d  = col_last;
`ifdef IRCAM_FRAME_CHKSUM_EN
            sum_d  = sum_q + i_byte;
`endif
            if (col_last) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            if (col_last && row_last) begin
              row_d = '0;
`ifdef IRCAM_FRAME_CHKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_IDLE;
              pend_d  = 1'b1;
`endif
            end
          end else if (tmo_hit) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
            tmo_d   = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
`ifdef IRCAM_FRAME_CHKSUM_EN
            sum_d   = '0;
`endif
          end
        end
`ifdef IRCAM_FRAME_CHKSUM_EN
        S_CHECK: begin
          if (i_byte_vld) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = (i_byte != sum_q);
            sum_d   = '0;
          end else if (tmo_hit) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            sum_d   = '0;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge din_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef IRCAM_FRAME_CHKSUM_EN
      sum_q   <= '0;
`else
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef IRCAM_FRAME_CHKSUM_EN
      sum_q   <= sum_d;
`else
      pend_q  <= pend_d;
`endif
    end
  end

  assign o_data       = data_q;
  assign o_data_vld   = vld_q;
  assign o_sof        = sof_q;
  assign o_eol        = eol_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_ircam_frame_parser.sv
// Scoreboard bench for ircam_frame_parser with a small frame geometry (4 bytes x 2 rows, timeout 16).
// Covers both builds: IRCAM_FRAME_CHKSUM_EN selects the trailer-checking expectations.
module tb_ircam_frame_parser;

  localparam int ROW_BYTES   = 4;
  localparam int ROWS        = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int PAYLOAD     = ROW_BYTES * ROWS;

  logic       din_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b1;
  logic [7:0] i_byte  = 8'h00;
  logic       i_byte_vld = 1'b0;
  logic [7:0] o_data;
  logic       o_data_vld, o_sof, o_eol, o_frame_done, o_frame_err, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastDataCyc = 0;
  int doneCyc = 0;

  logic [9:0] expData[$];
  logic       expDone[$];

  ircam_frame_parser #(
    .HDR0(8'h5A), .HDR1(8'hA5),
    .ROW_BYTES(ROW_BYTES), .ROWS(ROWS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .din_clk(din_clk), .rst_n(rst_n), .en(en),
    .i_byte(i_byte), .i_byte_vld(i_byte_vld),
    .o_data(o_data), .o_data_vld(o_data_vld), .o_sof(o_sof), .o_eol(o_eol),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 din_clk = ~din_clk;

  always @(posedge din_clk) cyc = cyc + 1;

  // Every output pulse is matched against the scoreboard; anything not predicted is an error.
  always @(negedge din_clk) begin
    logic [9:0] e;
    logic       ed;
    if (rst_n) begin
      if (o_data_vld) begin
        checks++;
        lastDataCyc = cyc;
        if (expData.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_data got data %02h sof %0b eol %0b required none", o_data, o_sof, o_eol);
        end else begin
          e = expData.pop_front();
          if ({o_sof, o_eol, o_data} !== e) begin
            errors++;
            $display("[TB] FAIL data_out got sof %0b eol %0b data %02h required sof %0b eol %0b data %02h",
                     o_sof, o_eol, o_data, e[9], e[8], e[7:0]);
          end
        end
      end else if (o_sof || o_eol) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_marker got sof %0b eol %0b required 0 0", o_sof, o_eol);
      end
      if (o_frame_done) begin
        checks++;
        doneCyc = cyc;
        if (expDone.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done got err %0b required no done", o_frame_err);
        end else begin
          ed = expDone.pop_front();
          if (o_frame_err !== ed) begin
            errors++;
            $display("[TB] FAIL frame_err got %0b required %0b", o_frame_err, ed);
          end
        end
      end else if (o_frame_err) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_err got 1 required 0");
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b);
    i_byte = b;
    i_byte_vld = 1'b1;
    @(posedge din_clk);
    #1;
    i_byte_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge din_clk);
      #1;
    end
  endtask

  task automatic push_payload(input int i, input logic [7:0] b);
    expData.push_back({(i == 0), ((i % ROW_BYTES) == ROW_BYTES - 1), b});
  endtask

  // Payload is firstByte, firstByte+1, ...; trailer is the true sum plus chkDelta.
  task automatic send_frame(input logic [7:0] firstByte, input logic [7:0] chkDelta);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    drive_byte(8'h5A);
    drive_byte(8'hA5);
    for (int i = 0; i < PAYLOAD; i++) begin
      b = firstByte + 8'(i);
      sum = sum + b;
      push_payload(i, b);
      drive_byte(b);
    end
`ifdef IRCAM_FRAME_CHKSUM_EN
    expDone.push_back(chkDelta != 8'h00);
    drive_byte(sum + chkDelta);
`else
    expDone.push_back(1'b0);
`endif
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 64;
    while ((expData.size() != 0 || expDone.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(3);
    checks++;
    if (expData.size() != 0 || expDone.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain got %0d data %0d done pending required 0 0", name, expData.size(), expDone.size());
      expData.delete();
      expDone.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy got %0b required 0", name, o_busy);
    end
  endtask

  task automatic test_reset;
    idle(2);
    checks++;
    if ({o_data, o_data_vld, o_sof, o_eol, o_frame_done, o_frame_err, o_busy} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %02h %b%b%b%b%b%b required all 0",
               o_data, o_data_vld, o_sof, o_eol, o_frame_done, o_frame_err, o_busy);
    end
    rst_n = 1'b1;
    idle(2);
    check_idle("reset");
  endtask

  task automatic test_good_frame;
    send_frame(8'h01, 8'h00);
    wait_drain("good");
    check_idle("good");
  endtask

  task automatic test_bad_checksum;
`ifdef IRCAM_FRAME_CHKSUM_EN
    send_frame(8'h01, 8'h01);
    wait_drain("badchk");
    send_frame(8'h01, 8'h00);
    wait_drain("badchk_recover");
`endif
  endtask

  task automatic test_resync;
    drive_byte(8'h5A);
    send_frame(8'h01, 8'h00);
    wait_drain("resync_5a5a");
    drive_byte(8'h5A);
    drive_byte(8'h00);
    drive_byte(8'hA5);
    drive_byte(8'h11);
    drive_byte(8'h22);
    drive_byte(8'h33);
    idle(3);
    check_idle("resync_broken");
    wait_drain("resync_broken");
    send_frame(8'h01, 8'h00);
    wait_drain("resync_after");
  endtask

  task automatic test_timeout;
    int lastCyc;
    int gap;
    drive_byte(8'h5A);
    drive_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      push_payload(i, 8'h41 + 8'(i));
      drive_byte(8'h41 + 8'(i));
    end
    lastCyc = cyc;
    expDone.push_back(1'b1);
    idle(TIMEOUT_CYC + 4);
    wait_drain("timeout");
    gap = doneCyc - lastCyc;
    checks++;
    if (gap < TIMEOUT_CYC - 1 || gap > TIMEOUT_CYC + 1) begin
      errors++;
      $display("[TB] FAIL timeout_latency got %0d required %0d..%0d", gap, TIMEOUT_CYC - 1, TIMEOUT_CYC + 1);
    end
    check_idle("timeout");
    drive_byte(8'h5A);
    idle(TIMEOUT_CYC + 4);
    check_idle("h0_timeout");
    wait_drain("h0_timeout");
    send_frame(8'h01, 8'h00);
    wait_drain("timeout_recover");
  endtask

  task automatic test_enable;
    drive_byte(8'h5A);
    drive_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      push_payload(i, 8'h01 + 8'(i));
      drive_byte(8'h01 + 8'(i));
    end
    en = 1'b0;
    drive_byte(8'h06);
    drive_byte(8'h07);
    drive_byte(8'h08);
    drive_byte(8'h24);
    idle(2);
    check_idle("en_low");
    en = 1'b1;
    drive_byte(8'h09);
    idle(TIMEOUT_CYC + 4);
    wait_drain("en_abort");
    send_frame(8'h01, 8'h00);
    wait_drain("en_recover");
  endtask

  task automatic test_back_to_back;
    send_frame(8'h58, 8'h00);
    send_frame(8'hA2, 8'h00);
    wait_drain("b2b");
    check_idle("b2b");
  endtask

  task automatic test_macro_off;
`ifndef IRCAM_FRAME_CHKSUM_EN
    send_frame(8'h01, 8'h00);
    drive_byte(8'h24);
    wait_drain("nochk");
    checks++;
    if (doneCyc != lastDataCyc + 1) begin
      errors++;
      $display("[TB] FAIL nochk_done_timing got %0d required %0d", doneCyc, lastDataCyc + 1);
    end
`endif
  endtask

  task automatic test_async_reset;
    drive_byte(8'h5A);
    drive_byte(8'hA5);
    push_payload(0, 8'h77);
    drive_byte(8'h77);
    push_payload(1, 8'h78);
    drive_byte(8'h78);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data_vld, o_frame_done, o_busy, o_data} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got vld %0b done %0b busy %0b data %02h required 0",
               o_data_vld, o_frame_done, o_busy, o_data);
    end
    expData.delete();
    @(posedge din_clk);
    #1;
    rst_n = 1'b1;
    idle(TIMEOUT_CYC + 4);
    wait_drain("async_reset");
    send_frame(8'h01, 8'h00);
    wait_drain("async_recover");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_resync();
    test_timeout();
    test_enable();
    test_back_to_back();
    test_macro_off();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
